// File: rtl/hb_wb_pkg.sv
// Shared types and constants for the host-bus to Wishbone bridge.
package hb_wb_pkg;

    // Bridge FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } hb_state_t;

    // Read data handed back on err/timeout; sliced to DATA_WIDTH by the user
    localparam logic [63:0] ERR_DATA_ALL = {64{1'b1}};

    // Width of a counter that must reach n-1; never narrower than 1 bit
    function automatic int tmo_cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hb_wb_bridge_sync_if.sv
// Classic Wishbone B4 single-master bus between bridge and interconnect.
interface hb_wb_bridge_sync_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/hb_sync_bit.sv
// Single-bit multi-flop synchroniser; resets to 1 so active-low strobes read idle.
module hb_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (rst) ff <= '1;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/hb_wb_bridge_sync.sv
// Asynchronous active-low host bus to Wishbone B4 classic single master.
// One Wishbone cycle per host access; completion reported on hb_rdy.
module hb_wb_bridge_sync
    import hb_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = ERR_DATA_ALL[DATA_WIDTH-1:0]
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hb_cs_n,
    input  logic                  hb_oe_n,
    input  logic                  hb_we_n,
    input  logic [ADDR_WIDTH-1:0] hb_addr,
    inout  wire  [DATA_WIDTH-1:0] hb_data,
    output logic                  hb_rdy,
    hb_wb_bridge_sync_if.master   wb,
    output logic                  err_flag,
    input  logic                  err_clr
);
    localparam int CW = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic cs_s, oe_s, we_s;

    hb_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .rst(rst), .d(hb_cs_n), .q(cs_s));
    hb_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (.clk(clk), .rst(rst), .d(hb_oe_n), .q(oe_s));
    hb_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_we (.clk(clk), .rst(rst), .d(hb_we_n), .q(we_s));

    hb_state_t             state;
    logic [CW-1:0]         tmo_cnt;
    logic                  is_read;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  abort;
    logic                  data_oe;

    // Abort on err (wins over a simultaneous ack) or on the last allowed wait cycle
    always_comb begin
        abort = 1'b0;
        if (state == ST_REQ)
            abort = wb.wb_err_i || (!wb.wb_ack_i && tmo_cnt == TMO_LAST);
    end

    // Bridge FSM with registered Wishbone/host outputs and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            is_read     <= 1'b0;
            rdata       <= '0;
            hb_rdy      <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            err_flag    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cs_s && (!we_s || !oe_s)) begin
                        wb.wb_adr_o <= hb_addr;
                        if (!we_s) begin
                            wb.wb_dat_o <= hb_data;
                            wb.wb_we_o  <= 1'b1;
                            is_read     <= 1'b0;
                        end else begin
                            wb.wb_we_o  <= 1'b0;
                            is_read     <= 1'b1;
                        end
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (abort) begin
                        rdata       <= ERR_DATA;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        hb_rdy      <= 1'b1;
                        state       <= ST_DONE;
                    end else if (wb.wb_ack_i) begin
                        if (is_read) rdata <= wb.wb_dat_i;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        hb_rdy      <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Host must deassert cs before another access is accepted
                    if (cs_s) begin
                        hb_rdy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (abort)        err_flag <= 1'b1;
            else if (err_clr) err_flag <= 1'b0;
        end
    end

    // Raw pins gate the driver so the bus is released without sync delay
    assign data_oe = (state == ST_DONE) && is_read && !hb_oe_n && !hb_cs_n;
    assign hb_data = data_oe ? rdata : 'z;

endmodule

// File: tb/tb_hb_wb_bridge_sync.sv
// Directed bench for hb_wb_bridge_sync with a hand-driven Wishbone slave.
module tb_hb_wb_bridge_sync;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int SS  = 2;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hb_cs_n = 1'b1, hb_oe_n = 1'b1, hb_we_n = 1'b1;
    logic [AW-1:0] hb_addr = '0;
    logic          tb_drv = 1'b0;
    logic [DW-1:0] tb_val = '0;
    wire  [DW-1:0] hb_data;
    logic          hb_rdy, err_flag;
    logic          err_clr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    hb_wb_bridge_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb();

    assign hb_data = tb_drv ? tb_val : 'z;

    hb_wb_bridge_sync #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .hb_cs_n(hb_cs_n), .hb_oe_n(hb_oe_n), .hb_we_n(hb_we_n),
        .hb_addr(hb_addr), .hb_data(hb_data), .hb_rdy(hb_rdy),
        .wb(wb), .err_flag(err_flag), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start an access at a negedge and play slave until hb_rdy; resp_at=0 means never respond
    task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int resp_at, input bit use_err, input logic [DW-1:0] sd,
                          output int n_stb, output int lat,
                          output logic [AW-1:0] s_adr, output logic [DW-1:0] s_dat, output logic s_we);
        bit done;
        done = 0; n_stb = 0; lat = 0;
        s_adr = '0; s_dat = '0; s_we = 1'b0;
        hb_addr = a;
        if (wr) begin tb_drv = 1'b1; tb_val = d; hb_we_n = 1'b0; end
        else    hb_oe_n = 1'b0;
        hb_cs_n = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            lat++;
            wb.wb_ack_i = 1'b0;
            wb.wb_err_i = 1'b0;
            if (hb_rdy) done = 1;
            else if (wb.wb_stb_o && wb.wb_cyc_o) begin
                n_stb++;
                s_adr = wb.wb_adr_o; s_dat = wb.wb_dat_o; s_we = wb.wb_we_o;
                if (n_stb == resp_at) begin
                    wb.wb_ack_i = !use_err;
                    wb.wb_err_i = use_err;
                    wb.wb_dat_i = sd;
                end
            end
        end
        chk("rdy_within_bound", {31'b0, done}, 32'd1);
    endtask

    task automatic end_access();
        bit gone;
        gone = 0;
        hb_cs_n = 1'b1; hb_oe_n = 1'b1; hb_we_n = 1'b1; tb_drv = 1'b0;
        for (int i = 0; i < 20 && !gone; i++) begin
            @(negedge clk);
            if (!hb_rdy) gone = 1;
        end
        chk("rdy_release", {31'b0, gone}, 32'd1);
        @(negedge clk);
    endtask

    int            ns, lt, cnt;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic          sw;

    initial begin
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_dat_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'b0, hb_rdy}, 0);
        chk("rst_cyc", {31'b0, wb.wb_cyc_o}, 0);
        chk("rst_stb", {31'b0, wb.wb_stb_o}, 0);
        chk("rst_we",  {31'b0, wb.wb_we_o}, 0);
        chk("rst_adr", {16'b0, wb.wb_adr_o}, 0);
        chk("rst_dat", {16'b0, wb.wb_dat_o}, 0);
        chk("rst_err", {31'b0, err_flag}, 0);
        chk("rst_oe",  {31'b0, dut.data_oe}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write, ack on third strobe cycle
        access(1'b1, 16'h1234, 16'hBEEF, 3, 1'b0, 16'h0, ns, lt, sa, sd, sw);
        chk("wr_nstb", ns, 3);
        chk("wr_adr", {16'b0, sa}, 32'h1234);
        chk("wr_dat", {16'b0, sd}, 32'hBEEF);
        chk("wr_we", {31'b0, sw}, 1);
        chk("wr_cyc_drop", {31'b0, wb.wb_cyc_o}, 0);
        chk("wr_err", {31'b0, err_flag}, 0);
        end_access();
        chk("wr_adr_hold", {16'b0, wb.wb_adr_o}, 32'h1234);

        // Read, immediate ack
        access(1'b0, 16'h0042, 16'h0, 1, 1'b0, 16'hA5A5, ns, lt, sa, sd, sw);
        chk("rd_lat", lt, SS + 2);
        chk("rd_we", {31'b0, sw}, 0);
        chk("rd_adr", {16'b0, sa}, 32'h0042);
        chk("rd_data", {16'b0, hb_data}, 32'hA5A5);
        chk("rd_oe", {31'b0, dut.data_oe}, 1);
        hb_oe_n = 1'b1;
        #1;
        chk("rd_release", {31'b0, dut.data_oe}, 0);
        end_access();

        // Read terminated by err
        access(1'b0, 16'h0100, 16'h0, 2, 1'b1, 16'h1234, ns, lt, sa, sd, sw);
        chk("err_data", {16'b0, hb_data}, 32'hFFFF);
        chk("err_flag_set", {31'b0, err_flag}, 1);
        end_access();
        chk("err_flag_sticky", {31'b0, err_flag}, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_flag_clr", {31'b0, err_flag}, 0);

        // Timeout with err_clr held: set must win on the abort edge
        err_clr = 1'b1;
        access(1'b0, 16'h0200, 16'h0, 0, 1'b0, 16'h0, ns, lt, sa, sd, sw);
        chk("tmo_nstb", ns, TMO);
        chk("tmo_cyc", {31'b0, wb.wb_cyc_o}, 0);
        chk("tmo_data", {16'b0, hb_data}, 32'hFFFF);
        chk("tmo_err_set_wins", {31'b0, err_flag}, 1);
        @(negedge clk);
        chk("tmo_err_clr_next", {31'b0, err_flag}, 0);
        err_clr = 1'b0;
        end_access();

        // Reset during REQ
        hb_addr = 16'h0300; hb_oe_n = 1'b0; hb_cs_n = 1'b0;
        cnt = 0;
        while (!wb.wb_stb_o && cnt < 20) begin @(negedge clk); cnt++; end
        chk("mrst_stb_seen", {31'b0, wb.wb_stb_o}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_cyc", {31'b0, wb.wb_cyc_o}, 0);
        chk("mrst_stb", {31'b0, wb.wb_stb_o}, 0);
        chk("mrst_rdy", {31'b0, hb_rdy}, 0);
        chk("mrst_oe", {31'b0, dut.data_oe}, 0);
        hb_cs_n = 1'b1; hb_oe_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        access(1'b0, 16'h0400, 16'h0, 1, 1'b0, 16'h1111, ns, lt, sa, sd, sw);
        chk("mrst_after_data", {16'b0, hb_data}, 32'h1111);
        chk("mrst_after_lat", lt, SS + 2);
        end_access();

        // Host holds cs low: no repeated Wishbone cycle
        access(1'b0, 16'h0500, 16'h0, 1, 1'b0, 16'h2222, ns, lt, sa, sd, sw);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb.wb_cyc_o) cnt++;
        end
        chk("hold_no_repeat", cnt, 0);
        chk("hold_rdy", {31'b0, hb_rdy}, 1);
        end_access();
        access(1'b0, 16'h0501, 16'h0, 1, 1'b0, 16'h3333, ns, lt, sa, sd, sw);
        chk("hold_second_nstb", ns, 1);
        chk("hold_second_data", {16'b0, hb_data}, 32'h3333);
        end_access();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hb_wb_bridge_sync.md
Name: hb_wb_bridge_sync

Overview:
- Registered successor to the combinational host-bus/Wishbone wrapper.
- Synchronises the asynchronous active-low host bus (cs/oe/we) into clk.
- Runs one classic Wishbone B4 single-cycle transaction per host access, with real ack/err handling and a timeout, and reports completion to the host through hb_rdy.
- Sits between the external host-bus pins and the internal Wishbone interconnect, as its single master.

Parameters:
- DATA_WIDTH, 16, width of host and Wishbone data.
- ADDR_WIDTH, 16, width of host and Wishbone address.
- SYNC_STAGES, 2, flip-flop stages on each host control input; legal range ≥2.
- TIMEOUT_CYCLES, 64, clk cycles a Wishbone request may wait for ack/err before abort; ≥2.
- ERR_DATA, all ones (DATA_WIDTH bits), read data returned on err or timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- hb_cs_n  in  1  host chip select, active low, asynchronous.
- hb_oe_n  in  1  host output enable (read), active low, asynchronous.
- hb_we_n  in  1  host write enable, active low, asynchronous.
- hb_addr  in  ADDR_WIDTH  host address.
- hb_data  inout  DATA_WIDTH  host data bus.
- hb_rdy  out  1  access complete; host may sample read data or end the write.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- err_flag  out  1  sticky: a Wishbone err or timeout has occurred.
- err_clr  in  1  one-cycle pulse, clears err_flag.

Behaviour:
- Reset:
  - rst is synchronous, active-high.
  - All registered outputs go to 0: hb_rdy, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, err_flag.
  - Synchroniser chains reset to inactive (1).
  - hb_data is released (Z).
  - FSM enters IDLE.
  - Reset mid-transaction drops cyc/stb at that edge and does not generate hb_rdy.
- Synchronisation:
  - cs_s, oe_s, we_s are the SYNC_STAGES-deep synchronised versions of the host controls.
  - hb_addr and hb_data are not synchronised.
  - The host must hold them stable from cs_n falling until hb_rdy is seen.
- FSM states:
  - IDLE:
    - When cs_s=0 and (we_s=0 or oe_s=0), capture hb_addr into wb_adr_o.
    - If we_s=0, capture hb_data into wb_dat_o and set wb_we_o=1 (write has priority if both are low).
    - Otherwise set wb_we_o=0 and set internal is_read.
    - Go to REQ; wb_cyc_o=wb_stb_o=1 from the next cycle.
  - REQ:
    - Hold cyc/stb/we/adr/dat constant.
    - Timeout counter increments each cycle.
    - wb_ack_i=1: latch wb_dat_i into rdata if is_read; drop cyc/stb; go to DONE.
    - wb_err_i=1 (ack and err both high counts as err): rdata=ERR_DATA; set err_flag; drop cyc/stb; go to DONE.
    - Counter reaches TIMEOUT_CYCLES-1 with neither: same as err (abort, ERR_DATA, err_flag).
  - DONE:
    - hb_rdy=1.
    - hb_data is driven with rdata only while is_read and raw hb_oe_n=0 and raw hb_cs_n=0; the raw pins give fast bus release.
    - When cs_s=1, drop hb_rdy and go to IDLE.
    - The host holding cs low keeps the FSM in DONE; no repeat access occurs.
- Latency:
  - From the synchronised strobe being seen in IDLE: cyc/stb rise 1 cycle later.
  - For an ack in the first REQ cycle, hb_rdy rises 2 cycles after the IDLE capture.
  - Total from pin edge: SYNC_STAGES+2 cycles minimum.
- Back-to-back accesses:
  - A new access is only recognised in IDLE.
  - Therefore cs_n must go high (and be synchronised) between accesses.
- err_flag:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr clears it.
- Address and write data are held on the Wishbone outputs after the cycle ends, until the next capture.

Decomposition:
- Package hb_wb_pkg:
  - FSM state encoding (IDLE, REQ, DONE).
  - Default ERR_DATA pattern constant.
  - Timeout counter width function (clog2 of TIMEOUT_CYCLES).
- Sub-module hb_sync_bit:
  - Parameterised SYNC_STAGES synchroniser with reset value 1.
  - Instantiated three times (cs, oe, we).

Test Plan:
- Write: addr=0x1234, data=0xBEEF, we_n low; slave acks on the 3rd stb cycle -> one cycle with cyc=stb=we=1, adr=0x1234, dat=0xBEEF; hb_rdy after ack; err_flag=0.
- Read: addr=0x0042; slave returns 0xA5A5 with immediate ack -> hb_rdy at SYNC_STAGES+2 cycles; hb_data=0xA5A5 while oe_n low; Z once oe_n rises.
- Error: slave asserts err on a read -> hb_data=0xFFFF; err_flag=1 until an err_clr pulse, then 0.
- Timeout: slave never responds, TIMEOUT_CYCLES=8 -> cyc drops after exactly 8 REQ cycles; hb_rdy=1; read data 0xFFFF; err_flag=1.
- Reset mid-REQ: assert rst while stb=1 -> next edge cyc=stb=0, hb_rdy=0, hb_data Z; a later access completes normally.
- Host holds cs_n low after hb_rdy for 20 cycles, then repeats -> exactly one Wishbone cycle until cs_n goes high; a second cycle only after re-strobe.
